// File: rtl/srl_fifo_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// srl_fifo_pkg : shared sizing helpers and option constants for srl_fifo
// Rev 1.0
// ----------------------------------------------------------------------------
package srl_fifo_pkg;

    localparam string OUT_REG_ON = "true";

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    // Wide enough for DEPTH+1 words (store plus optional output stage).
    function automatic int count_width(input int aw);
        return $clog2((1 << aw) + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/srl_tap_store.sv
`default_nettype none
// ----------------------------------------------------------------------------
// srl_tap_store : shift-in tap-delay array with asynchronous addressed read
// Rev 1.0
// ----------------------------------------------------------------------------
module srl_tap_store
    import srl_fifo_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          ce,
    input  logic [DW-1:0] d,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] q
);

    localparam int DEPTH = depth_of(AW);

    // No reset so the array maps onto dynamic shift-register primitives.
    logic [DW-1:0] taps_q [DEPTH];

    always_ff @(posedge clk) begin
        if (ce) begin
            taps_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                taps_q[i] <= taps_q[i-1];
            end
        end
    end

    assign q = taps_q[addr];

endmodule
`default_nettype wire

// File: rtl/srl_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// srl_fifo : valid/ready FIFO on a tap-delay store, optional output register
// Rev 1.0
// ----------------------------------------------------------------------------
module srl_fifo
    import srl_fifo_pkg::*;
#(
    parameter int    AW      = 4,
    parameter int    DW      = 8,
    parameter string OUT_REG = "false"
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DW-1:0]                 s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DW-1:0]                 m_data,
    output logic [count_width(AW)-1:0]    count
);

    localparam int            DEPTH    = depth_of(AW);
    localparam int            CW       = count_width(AW);
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam bit            USE_OREG = (OUT_REG == OUT_REG_ON);

    logic [CW-1:0] sc_q, sc_d;
    logic          s_ready_q, s_ready_d;
    logic          push;
    logic          st_pop;
    logic          st_nonempty;
    logic [AW-1:0] ptr;
    logic [DW-1:0] tap_rd;

    assign push        = s_valid & s_ready_q;
    assign st_nonempty = (sc_q != '0);
    assign ptr         = AW'(sc_q - ONE_C);
    assign s_ready     = s_ready_q;

    srl_tap_store #(
        .AW (AW),
        .DW (DW)
    ) u_store (
        .clk  (clk),
        .ce   (push),
        .d    (s_data),
        .addr (ptr),
        .q    (tap_rd)
    );

    // Push and pop together leave sc alone: the shift itself advances the head.
    always_comb begin
        sc_d = sc_q;
        if (push && !st_pop) begin
            sc_d = sc_q + ONE_C;
        end else if (!push && st_pop) begin
            sc_d = sc_q - ONE_C;
        end
    end

    assign s_ready_d = (sc_d < FULL_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q      <= '0;
            s_ready_q <= 1'b0;
        end else begin
            sc_q      <= sc_d;
            s_ready_q <= s_ready_d;
        end
    end

    if (USE_OREG) begin : g_oreg
        logic          ov_q, ov_d;
        logic [DW-1:0] od_q, od_d;
        logic          load;

        assign load = st_nonempty & (~ov_q | m_ready);

        always_comb begin
            ov_d = ov_q;
            od_d = od_q;
            if (load) begin
                ov_d = 1'b1;
                od_d = tap_rd;
            end else if (m_ready) begin
                ov_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ov_q <= 1'b0;
                od_q <= '0;
            end else begin
                ov_q <= ov_d;
                od_q <= od_d;
            end
        end

        assign st_pop  = load;
        assign m_valid = ov_q;
        assign m_data  = od_q;
        assign count   = sc_q + CW'(ov_q);
    end else begin : g_comb
        assign st_pop  = st_nonempty & m_ready;
        assign m_valid = st_nonempty;
        assign m_data  = tap_rd;
        assign count   = sc_q;
    end

    a_sc_range: assert property (@(posedge clk) disable iff (!rst_n) sc_q <= FULL_C);

endmodule
`default_nettype wire
